symbol_mapper: RTL and testbench
================================

SYMBOL_MAPPER -- requirements
Module: symbol_mapper

Interface
REQ-001 SHALL have parameter NSD, default 48, data subcarriers per OFDM symbol.
REQ-002 SHALL have parameter LEVEL_W, default 4, signed width of each I/Q level.
REQ-003 SHALL have port clock, input, 1, sole clock; all logic on rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-low reset; reset==0 at a rising edge resets the block.
REQ-005 SHALL have port start, input, 1, one-cycle frame-start pulse: latches Rate and clears all counters.
REQ-006 SHALL have port Rate, input, 4, 802.11a RATE field; sampled only when start==1.
REQ-007 SHALL have port inputData, input, 1, serial interleaved bit; first received bit is b0.
REQ-008 SHALL have port inputValid, input, 1, inputData is valid this cycle.
REQ-009 SHALL have port I_out, output, LEVEL_W, signed in-phase level.
REQ-010 SHALL have port Q_out, output, LEVEL_W, signed quadrature level.
REQ-011 SHALL have port outputValid, output, 1, one-cycle pulse per mapped subcarrier.
REQ-012 SHALL have port carrierIndex, output, 6, subcarrier index 0..NSD-1 of the current I/Q.
REQ-013 SHALL have port symbolEnd, output, 1, high with outputValid when carrierIndex==NSD-1.

Function
REQ-014 SHALL decode the latched Rate to N_BPSC: 1011/1111 BPSK (1); 1010/1110 QPSK (2); 1001/1101 16-QAM (4); 1000/1100 64-QAM (6); any other value BPSK.
REQ-015 SHALL collect bits into a group register with a bit counter 0..N_BPSC-1, advancing only when inputValid==1.
REQ-016 SHALL, in the cycle after the last bit of a group is accepted, drive I_out/Q_out and pulse outputValid. Latency is exactly 1 clock from the last accepted bit.
REQ-017 SHALL hold I_out/Q_out/carrierIndex stable between pulses; outputValid is low otherwise.
REQ-018 SHALL map BPSK: b0=0 -> I=-1, b0=1 -> I=+1; Q=0.
REQ-019 SHALL map QPSK: I from b0, Q from b1, each 0->-1, 1->+1.
REQ-020 SHALL map 16-QAM: I from b0b1, Q from b2b3; 00->-3, 01->-1, 11->+1, 10->+3.
REQ-021 SHALL map 64-QAM: I from b0b1b2, Q from b3b4b5; 000->-7, 001->-5, 011->-3, 010->-1, 110->+1, 111->+3, 101->+5, 100->+7.
REQ-022 SHALL emit levels as unnormalised integers in two's complement; KMOD scaling is out of scope.
REQ-023 SHALL increment carrierIndex after each outputValid and wrap NSD-1 -> 0. symbolEnd is asserted on the wrapping pulse.
REQ-024 SHALL treat start as highest priority. A start coincident with inputValid discards that bit, discards any partial group, sets bit counter and carrierIndex to 0, and takes the new Rate.
REQ-025 SHALL, when inputValid drops mid-group, hold the partial group indefinitely without timeout.
REQ-026 SHALL accept back-to-back valid bits every cycle with no stall. Throughput is 1 bit per clock.
REQ-027 SHALL use a two-state FSM: IDLE (after reset; ignores inputValid) and MAP (entered on start). From MAP, start re-enters MAP and reset returns to IDLE.

Reset
REQ-028 SHALL, on reset==0, drive I_out=0, Q_out=0, outputValid=0, carrierIndex=0, symbolEnd=0, clear the bit counter and group register, set the latched Rate to BPSK, and enter IDLE.
REQ-029 SHALL, on reset mid-group or mid-symbol, discard all partial state with no outputValid issued for it.

Structure
REQ-030 SHALL place the modulation enumeration, the Rate-to-N_BPSC table, NSD and the Gray level tables in a shared package phy_pkg.
REQ-031 SHALL implement the 3-bit Gray-to-level lookup as the sub-module gray_level_map, instantiated for I and Q.

Verification
REQ-032 Bench SHALL check: start with Rate=1011, bits 1,0 -> (I,Q)=(+1,0) then (-1,0), each one cycle after its bit.
REQ-033 Bench SHALL check: Rate=1001, bits 1,0,0,1 -> (I,Q)=(+3,-1).
REQ-034 Bench SHALL check: Rate=1100, bits 1,1,0,0,0,1 -> (I,Q)=(+1,-5).
REQ-035 Bench SHALL check: Rate=1010, 96 continuous bits -> 48 pulses, carrierIndex 0..47, symbolEnd only on index 47, then index wraps to 0.
REQ-036 Bench SHALL check: Rate=1000, 3 bits, then start with Rate=1011 and bit 1 -> no 64-QAM output, next output (+1,0) at carrierIndex 0.
REQ-037 Bench SHALL check: reset==0 after 2 of 4 16-QAM bits, then start and 4 bits 0000 -> single output (-3,-3) at index 0.

Source files
------------

// File: rtl/phy_pkg.sv
// Shared 802.11a PHY definitions: modulation types, RATE decode, subcarrier count
// and the Gray-coded constellation level tables.
package phy_pkg;

  localparam int unsigned PHY_NSD = 48;

  typedef enum logic [1:0] {
    ModBpsk,
    ModQpsk,
    Mod16Qam,
    Mod64Qam
  } mod_e;

  localparam logic signed [3:0] LVL_P1 = 4'sb0001;
  localparam logic signed [3:0] LVL_M1 = 4'sb1111;

  // Indexed by the Gray bits in arrival order, earliest bit as MSB.
  localparam logic signed [3:0] GRAY16_LUT [4] = '{-4'sd3, -4'sd1, 4'sd3, 4'sd1};
  localparam logic signed [3:0] GRAY64_LUT [8] = '{-4'sd7, -4'sd5, -4'sd1, -4'sd3,
                                                    4'sd7,  4'sd5,  4'sd1,  4'sd3};

  function automatic mod_e rate_to_mod(input logic [3:0] rate);
    case (rate)
      4'b1011, 4'b1111: rate_to_mod = ModBpsk;
      4'b1010, 4'b1110: rate_to_mod = ModQpsk;
      4'b1001, 4'b1101: rate_to_mod = Mod16Qam;
      4'b1000, 4'b1100: rate_to_mod = Mod64Qam;
      default:          rate_to_mod = ModBpsk;
    endcase
  endfunction

  function automatic logic [2:0] mod_nbpsc(input mod_e m);
    case (m)
      ModQpsk:  mod_nbpsc = 3'd2;
      Mod16Qam: mod_nbpsc = 3'd4;
      Mod64Qam: mod_nbpsc = 3'd6;
      default:  mod_nbpsc = 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/gray_level_map.sv
// Maps up to three Gray-coded bits of one axis to a signed constellation level.
module gray_level_map
  import phy_pkg::*;
#(
  parameter int unsigned LEVEL_W = 4
) (
  input  mod_e                       i_mod,
  input  logic [2:0]                 i_bits,
  output logic signed [LEVEL_W-1:0]  o_level
);

  logic signed [3:0] w_lvl;

  always_comb begin
    w_lvl = '0;
    case (i_mod)
      ModBpsk, ModQpsk: w_lvl = i_bits[0] ? LVL_P1 : LVL_M1;
      Mod16Qam:         w_lvl = GRAY16_LUT[i_bits[1:0]];
      Mod64Qam:         w_lvl = GRAY64_LUT[i_bits];
      default:          w_lvl = '0;
    endcase
  end

  assign o_level = LEVEL_W'(w_lvl);

endmodule

// File: rtl/symbol_mapper.sv
// 802.11a constellation mapper: gathers serial interleaved bits into N_BPSC groups
// and emits one registered I/Q pair per data subcarrier.
module symbol_mapper
  import phy_pkg::*;
#(
  parameter int unsigned NSD     = PHY_NSD,
  parameter int unsigned LEVEL_W = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic [3:0]                 Rate,
  input  logic                       inputData,
  input  logic                       inputValid,
  output logic signed [LEVEL_W-1:0]  I_out,
  output logic signed [LEVEL_W-1:0]  Q_out,
  output logic                       outputValid,
  output logic [5:0]                 carrierIndex,
  output logic                       symbolEnd
);

  typedef enum logic {StIdle, StMap} state_e;

  state_e      r_state;
  mod_e        r_mod;
  logic [2:0]  r_bitcnt;
  logic [5:0]  r_group;
  logic [5:0]  r_carrier;

  logic [5:0]  w_group;
  logic [2:0]  w_nbpsc;
  logic        w_last;
  logic [2:0]  w_i_bits;
  logic [2:0]  w_q_bits;
  logic signed [LEVEL_W-1:0] w_i_level;
  logic signed [LEVEL_W-1:0] w_q_level;

  // Group as it will be once the current bit lands; lets the last bit map with no extra cycle.
  always_comb begin
    w_group           = r_group;
    w_group[r_bitcnt] = inputData;
  end

  assign w_nbpsc = mod_nbpsc(r_mod);
  assign w_last  = (r_bitcnt == w_nbpsc - 3'd1);

  always_comb begin
    w_i_bits = '0;
    w_q_bits = '0;
    case (r_mod)
      ModQpsk: begin
        w_i_bits = {2'b00, w_group[0]};
        w_q_bits = {2'b00, w_group[1]};
      end
      Mod16Qam: begin
        w_i_bits = {1'b0, w_group[0], w_group[1]};
        w_q_bits = {1'b0, w_group[2], w_group[3]};
      end
      Mod64Qam: begin
        w_i_bits = {w_group[0], w_group[1], w_group[2]};
        w_q_bits = {w_group[3], w_group[4], w_group[5]};
      end
      default: w_i_bits = {2'b00, w_group[0]};
    endcase
  end

  gray_level_map #(.LEVEL_W(LEVEL_W)) u_map_i (
    .i_mod   (r_mod),
    .i_bits  (w_i_bits),
    .o_level (w_i_level)
  );

  gray_level_map #(.LEVEL_W(LEVEL_W)) u_map_q (
    .i_mod   (r_mod),
    .i_bits  (w_q_bits),
    .o_level (w_q_level)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state      <= StIdle;
      r_mod        <= ModBpsk;
      r_bitcnt     <= '0;
      r_group      <= '0;
      r_carrier    <= '0;
      I_out        <= '0;
      Q_out        <= '0;
      outputValid  <= 1'b0;
      carrierIndex <= '0;
      symbolEnd    <= 1'b0;
    end else begin
      outputValid <= 1'b0;
      symbolEnd   <= 1'b0;
      if (start) begin
        r_state      <= StMap;
        r_mod        <= rate_to_mod(Rate);
        r_bitcnt     <= '0;
        r_group      <= '0;
        r_carrier    <= '0;
        carrierIndex <= '0;
      end else if (r_state == StMap && inputValid) begin
        if (w_last) begin
          r_bitcnt     <= '0;
          r_group      <= '0;
          I_out        <= w_i_level;
          Q_out        <= (r_mod == ModBpsk) ? '0 : w_q_level;
          outputValid  <= 1'b1;
          carrierIndex <= r_carrier;
          symbolEnd    <= (r_carrier == 6'(NSD - 1));
          r_carrier    <= (r_carrier == 6'(NSD - 1)) ? '0 : r_carrier + 6'd1;
        end else begin
          r_bitcnt <= r_bitcnt + 3'd1;
          r_group  <= w_group;
        end
      end
    end
  end

endmodule

// File: tb/tb_symbol_mapper.sv
// Self-checking bench for symbol_mapper: vector table, directed corner sequences and
// a randomized run against a Gray-decode arithmetic reference model.
module tb_symbol_mapper;

  logic              clock;
  logic              reset;
  logic              start;
  logic [3:0]        Rate;
  logic              inputData;
  logic              inputValid;
  logic signed [3:0] I_out;
  logic signed [3:0] Q_out;
  logic              outputValid;
  logic [5:0]        carrierIndex;
  logic              symbolEnd;

  int n_pass = 0;
  int n_total = 0;

  symbol_mapper #(.NSD(48), .LEVEL_W(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .Rate         (Rate),
    .inputData    (inputData),
    .inputValid   (inputValid),
    .I_out        (I_out),
    .Q_out        (Q_out),
    .outputValid  (outputValid),
    .carrierIndex (carrierIndex),
    .symbolEnd    (symbolEnd)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] rate;
    int         nb;
    logic [0:5] bits;
    int         ei;
    int         eq;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_start(input logic [3:0] r);
    start = 1'b1; Rate = r; inputValid = 1'b0; inputData = 1'b0;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic b);
    inputValid = 1'b1; inputData = b;
    tick();
    inputValid = 1'b0;
  endtask

  // Gray bits (earliest bit as MSB) -> binary index -> evenly spaced odd level.
  function automatic int glevel(input int nb, input int v);
    int bin = 0;
    int acc = 0;
    for (int i = nb - 1; i >= 0; i--) begin
      acc = acc ^ ((v >> i) & 1);
      bin = bin * 2 + acc;
    end
    return 2 * bin - ((1 << nb) - 1);
  endfunction

  function automatic int rate_bits(input logic [3:0] r);
    case (r)
      4'b1011, 4'b1111: return 1;
      4'b1010, 4'b1110: return 2;
      4'b1001, 4'b1101: return 4;
      4'b1000, 4'b1100: return 6;
      default:          return 1;
    endcase
  endfunction

  // Reference model state
  bit m_idle;
  int m_nb;
  int m_q[$];
  int m_car;
  int e_v, e_i, e_q, e_idx, e_end;

  task automatic model_step(input bit rst_n, input bit st, input logic [3:0] r,
                            input bit v, input bit d);
    int n_axis, vi, vq;
    if (!rst_n) begin
      m_idle = 1; m_nb = 1; m_q.delete(); m_car = 0;
      e_v = 0; e_i = 0; e_q = 0; e_idx = 0; e_end = 0;
    end else begin
      e_v = 0; e_end = 0;
      if (st) begin
        m_idle = 0; m_nb = rate_bits(r); m_q.delete(); m_car = 0; e_idx = 0;
      end else if (!m_idle && v) begin
        m_q.push_back(int'(d));
        if (m_q.size() == m_nb) begin
          n_axis = (m_nb == 1) ? 1 : m_nb / 2;
          vi = 0; vq = 0;
          for (int k = 0; k < n_axis; k++) vi = vi * 2 + m_q[k];
          e_i = glevel(n_axis, vi);
          if (m_nb == 1) e_q = 0;
          else begin
            for (int k = n_axis; k < 2 * n_axis; k++) vq = vq * 2 + m_q[k];
            e_q = glevel(n_axis, vq);
          end
          e_v = 1; e_idx = m_car; e_end = (m_car == 47) ? 1 : 0;
          m_car = (m_car + 1) % 48;
          m_q.delete();
        end
      end
    end
  endtask

  initial begin
    logic b0, b1;
    int   exp_i;
    vecs[0]  = '{4'b1001, 4, 6'b100100,  3, -1};
    vecs[1]  = '{4'b1100, 6, 6'b110001,  1, -5};
    vecs[2]  = '{4'b1010, 2, 6'b010000, -1,  1};
    vecs[3]  = '{4'b1001, 4, 6'b000000, -3, -3};
    vecs[4]  = '{4'b1000, 6, 6'b100100,  7,  7};
    vecs[5]  = '{4'b1000, 6, 6'b000111, -7,  3};
    vecs[6]  = '{4'b0000, 1, 6'b000000, -1,  0};
    vecs[7]  = '{4'b1111, 1, 6'b100000,  1,  0};
    vecs[8]  = '{4'b1110, 2, 6'b100000,  1, -1};
    vecs[9]  = '{4'b1101, 4, 6'b101100,  3,  1};
    vecs[10] = '{4'b1000, 6, 6'b011010, -3, -1};
    vecs[11] = '{4'b0111, 1, 6'b100000,  1,  0};

    reset = 1'b0; start = 1'b0; Rate = 4'b0; inputData = 1'b0; inputValid = 1'b0;
    tick(); tick();
    chk("rst_I", int'(I_out), 0);
    chk("rst_Q", int'(Q_out), 0);
    chk("rst_valid", int'(outputValid), 0);
    chk("rst_idx", int'(carrierIndex), 0);
    chk("rst_end", int'(symbolEnd), 0);
    reset = 1'b1;

    // IDLE ignores valid bits until a start arrives
    for (int k = 0; k < 4; k++) begin
      send(1'b1);
      chk("idle_valid", int'(outputValid), 0);
    end

    // Vector table
    foreach (vecs[n]) begin
      do_start(vecs[n].rate);
      for (int k = 0; k < vecs[n].nb; k++) begin
        send(vecs[n].bits[k]);
        if (k < vecs[n].nb - 1) chk($sformatf("vec%0d_partial_valid", n), int'(outputValid), 0);
      end
      chk($sformatf("vec%0d_valid", n), int'(outputValid), 1);
      chk($sformatf("vec%0d_I", n), int'(I_out), vecs[n].ei);
      chk($sformatf("vec%0d_Q", n), int'(Q_out), vecs[n].eq);
      chk($sformatf("vec%0d_idx", n), int'(carrierIndex), 0);
    end

    // BPSK bits 1,0 one cycle each, then outputs hold
    do_start(4'b1011);
    send(1'b1);
    chk("bpsk1_valid", int'(outputValid), 1);
    chk("bpsk1_I", int'(I_out), 1);
    chk("bpsk1_Q", int'(Q_out), 0);
    send(1'b0);
    chk("bpsk2_valid", int'(outputValid), 1);
    chk("bpsk2_I", int'(I_out), -1);
    chk("bpsk2_idx", int'(carrierIndex), 1);
    tick();
    chk("hold_valid", int'(outputValid), 0);
    chk("hold_I", int'(I_out), -1);
    chk("hold_idx", int'(carrierIndex), 1);

    // Full QPSK symbol with wrap
    do_start(4'b1010);
    for (int p = 0; p < 49; p++) begin
      b0 = 1'($urandom_range(0, 1));
      b1 = 1'($urandom_range(0, 1));
      send(b0);
      chk("sym_mid_valid", int'(outputValid), 0);
      send(b1);
      chk("sym_valid", int'(outputValid), 1);
      chk("sym_idx", int'(carrierIndex), p % 48);
      chk("sym_end", int'(symbolEnd), (p == 47) ? 1 : 0);
      chk("sym_I", int'(I_out), glevel(1, int'(b0)));
      chk("sym_Q", int'(Q_out), glevel(1, int'(b1)));
    end

    // Partial 64-QAM group abandoned by a start that also drops its coincident bit
    do_start(4'b1000);
    send(1'b1); send(1'b0); send(1'b1);
    start = 1'b1; Rate = 4'b1011; inputValid = 1'b1; inputData = 1'b0;
    tick();
    start = 1'b0; inputValid = 1'b0;
    chk("restart_valid", int'(outputValid), 0);
    send(1'b1);
    chk("restart_out_valid", int'(outputValid), 1);
    chk("restart_I", int'(I_out), 1);
    chk("restart_Q", int'(Q_out), 0);
    chk("restart_idx", int'(carrierIndex), 0);

    // Reset mid-group discards the partial 16-QAM group
    do_start(4'b1001);
    send(1'b1); send(1'b1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("midrst_valid", int'(outputValid), 0);
    chk("midrst_I", int'(I_out), 0);
    do_start(4'b1001);
    for (int k = 0; k < 3; k++) begin
      send(1'b0);
      chk("midrst_partial_valid", int'(outputValid), 0);
    end
    send(1'b0);
    chk("midrst_out_valid", int'(outputValid), 1);
    chk("midrst_I_out", int'(I_out), -3);
    chk("midrst_Q_out", int'(Q_out), -3);
    chk("midrst_idx", int'(carrierIndex), 0);
    tick();
    chk("midrst_single", int'(outputValid), 0);

    // Randomized run against the reference model
    for (int c = 0; c < 3000; c++) begin
      bit r_n, st, v, d;
      logic [3:0] r;
      r_n = (c == 0) ? 1'b0 : ($urandom_range(0, 299) != 0);
      st  = (c == 1) ? 1'b1 : ($urandom_range(0, 49) == 0);
      r   = 4'($urandom_range(0, 15));
      v   = ($urandom_range(0, 3) != 0);
      d   = 1'($urandom_range(0, 1));
      reset = r_n; start = st; Rate = r; inputValid = v; inputData = d;
      model_step(r_n, st, r, v, d);
      tick();
      chk("rnd_valid", int'(outputValid), e_v);
      chk("rnd_I", int'(I_out), e_i);
      chk("rnd_Q", int'(Q_out), e_q);
      chk("rnd_idx", int'(carrierIndex), e_idx);
      chk("rnd_end", int'(symbolEnd), e_end);
    end
    reset = 1'b1; start = 1'b0; inputValid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
